// File: rtl/coord_pkg.sv
// Shared types and constants for the coordinate frame parser.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package coord_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CHECK   = 2'd3
    } state_t;

    localparam logic [7:0] HDR0_DEF      = 8'hAA;
    localparam logic [7:0] HDR1_DEF      = 8'h55;
    localparam int         PAYLOAD_BYTES = 12;
    localparam int         Q_FRAC_BITS   = 16;

    // Integer part (whole centimetres) of an unsigned Q16.16 coordinate.
    function automatic logic [15:0] q_int_part(input logic [31:0] v);
        return v[31:Q_FRAC_BITS];
    endfunction

endpackage

// File: rtl/coord_timeout_cnt.sv
// Inter-byte silence counter: clears on activity, counts while enabled, pulses on limit.
// Latency: expire is combinational from the current count; the count wraps to 0 on expiry.
// Backpressure: none; clr takes priority over expiry so a byte on the limit cycle wins.
module coord_timeout_cnt #(
    parameter int unsigned LIMIT = 50_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned     W    = (LIMIT > 2) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0]    LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: activity clears, otherwise count up and wrap with a pulse at the limit.
    always_comb begin
        cnt_d  = cnt_q;
        expire = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                expire = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/coord_frame_parser.sv
// Parses AA 55 + 12-byte x/y/z payload + additive checksum from a UART byte stream.
// Latency: x/y/z/valid/frame_cnt update on the edge after the checksum byte; err is a 1-cycle pulse.
// Backpressure: none; every rx_valid byte is consumed, valid is sticky until clr.
module coord_frame_parser
    import coord_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50_000,
    parameter logic [7:0]  HDR0           = HDR0_DEF,
    parameter logic [7:0]  HDR1           = HDR1_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        clr,
    output logic [31:0] x,
    output logic [31:0] y,
    output logic [31:0] z,
    output logic        valid,
    output logic        err,
    output logic [7:0]  frame_cnt
);

    localparam logic [3:0] LAST_IDX = 4'(PAYLOAD_BYTES - 1);

    state_t       state_q,     state_d;
    logic [3:0]   idx_q,       idx_d;
    logic [7:0]   sum_q,       sum_d;
    logic [95:0]  stage_q,     stage_d;
    logic [31:0]  x_q,         x_d;
    logic [31:0]  y_q,         y_d;
    logic [31:0]  z_q,         z_d;
    logic         valid_q,     valid_d;
    logic         err_q,       err_d;
    logic [7:0]   frame_cnt_q, frame_cnt_d;
    logic         tmo_expire;

    // Silence timer runs only mid-frame; any received byte restarts it.
    coord_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (rx_valid),
        .en     (state_q != ST_IDLE),
        .expire (tmo_expire)
    );

    // Frame FSM and output update; a completing good frame overrides a same-cycle clr.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        stage_d     = stage_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        valid_d     = valid_q;
        err_d       = 1'b0;
        frame_cnt_d = frame_cnt_q;

        if (clr) begin
            valid_d = 1'b0;
        end

        if (rx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_data == HDR0) begin
                        state_d = ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (rx_data == HDR1) begin
                        state_d = ST_PAYLOAD;
                        idx_d   = '0;
                        sum_d   = '0;
                    end else if (rx_data != HDR0) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PAYLOAD: begin
                    stage_d = {stage_q[87:0], rx_data};
                    sum_d   = sum_q + rx_data;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    state_d = ST_IDLE;
                    if (rx_data == sum_q) begin
                        x_d         = stage_q[95:64];
                        y_d         = stage_q[63:32];
                        z_d         = stage_q[31:0];
                        valid_d     = 1'b1;
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (tmo_expire) begin
            // Stalled sender: drop the partial frame and flag it.
            state_d = ST_IDLE;
            idx_d   = '0;
            sum_d   = '0;
            err_d   = 1'b1;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            sum_q       <= '0;
            stage_q     <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            stage_q     <= stage_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign z         = z_q;
    assign valid     = valid_q;
    assign err       = err_q;
    assign frame_cnt = frame_cnt_q;

endmodule
